jpeg_unstuff_bit_reader: RTL and testbench
==========================================

// Module: jpeg_unstuff_bit_reader
// PURPOSE
//  Decoder-side entropy front end, the receive counterpart of the encoder's byte-stuffing bit packer.
//  Accepts the compressed JPEG byte stream and removes the 0x00 stuffing byte that follows each 0xFF.
//  Detects markers (0xFF followed by a non-zero, non-0xFF byte) and holds them for the decoder.
//  Presents an MSB-first bit window to the Huffman decoder, which consumes a variable number of bits per cycle.
// PARAMETERS
//  BUF_W  32  bit-buffer capacity in bits; must be >= WIN_W+8
//  WIN_W  16  width of the peek window in bits (the longest Huffman code)
//  LEN_W   5  width of consume_len; 2**LEN_W > WIN_W
// PORTS
//  clk          in   1         single clock, rising edge
//  rst_n        in   1         asynchronous active-low reset
//  in_valid     in   1         in_data is valid
//  in_data      in   8         compressed stream byte
//  in_ready     out  1         byte accepted on an edge where in_valid && in_ready
//  peek_bits    out  WIN_W     oldest WIN_W buffered bits; MSB = oldest; bits beyond fill_level read 0
//  fill_level   out  clog2(BUF_W+1)  number of valid bits in the buffer
//  peek_valid   out  1         fill_level >= WIN_W
//  consume_en   in   1         remove consume_len bits this cycle
//  consume_len  in   LEN_W     bits to remove, 0..WIN_W
//  marker_valid out  1         marker pending; input is stalled
//  marker_code  out  8         second byte of the marker (e.g. D0..D7, D9)
//  marker_ack   in   1         releases the marker and flushes the bit buffer
//  err          out  1         sticky: over-consume or consume_len > WIN_W; cleared only by reset
// BEHAVIOUR
//  Reset (async assert, sync release):
//    state=NORMAL, fill_level=0, peek_bits=0, peek_valid=0, marker_valid=0, marker_code=0, err=0.
//    in_ready=1 in the first cycle after release.
//  FSM states and transitions (evaluated on an accepted byte):
//    NORMAL:  byte!=FF -> append 8 bits, stay in NORMAL.
//             byte==FF -> append nothing, go to GOT_FF.
//    GOT_FF:  byte==00 -> append 0xFF, go to NORMAL.
//             byte==FF -> fill byte, discard it, stay in GOT_FF.
//             any other byte -> marker_code=byte, marker_valid=1, go to MARKER; nothing appended.
//    MARKER:  in_ready=0. marker_ack -> fill_level=0, marker_valid=0, go to NORMAL.
//  in_ready = (state!=MARKER) && (fill_level <= BUF_W-8), computed from registered fill_level.
//    Same-cycle consume can only lower fill, so it cannot cause overflow.
//  Update order each cycle: fill_next = fill - (consume ? len : 0) + (appended ? 8 : 0).
//    Appended bits land directly below the remaining bits.
//  Latency: a byte accepted at edge k is visible in peek_bits/fill_level after edge k (1 cycle).
//    A consume at edge k shifts peek_bits after edge k.
//  consume_en with consume_len=0: no-op.
//  consume_len > fill_level or consume_len > WIN_W: buffer unchanged, err<=1.
//    A byte append in that cycle still occurs.
//  Consume is allowed in every state; in MARKER the decoder drains the residual bits before ack.
//  marker_ack together with consume_en: ack wins, fill=0.
//  marker_ack outside MARKER: ignored.
//  Reset asserted mid-operation (GOT_FF, MARKER, partial fill): all state is dropped immediately;
//    no partially stuffed byte survives.
// TESTING
//  1. Accept 12,34 -> fill_level=16, peek_bits=0x1234, peek_valid=1.
//  2. Accept FF,00,A5 -> fill_level=16, peek_bits=0xFFA5, marker_valid=0.
//  3. Accept 7E,FF,FF,D3 -> fill_level=8, marker_valid=1, marker_code=D3, in_ready=0.
//     Consume 8 -> fill 0. marker_ack -> marker_valid=0, in_ready=1.
//  4. Backpressure (BUF_W=32): accept 4 bytes -> fill=32, in_ready=0.
//     Consume 8 -> in_ready=1 next cycle. Consume 3 plus accept in same cycle -> fill=29.
//  5. fill=8, consume_len=9 -> fill stays 8, peek unchanged, err=1 and stays 1 after further valid traffic.
//  6. Accept FF (now in GOT_FF), assert rst_n=0 for 1 cycle, release, accept 00
//     -> fill=8, peek[15:8]=0x00, no marker.

Source files
------------

// File: rtl/jpeg_unstuff_bit_reader_if.sv
// Byte-stream input, bit-window output and marker handshake between the JPEG
// stream source / Huffman decoder and the unstuffing bit reader.
interface jpeg_unstuff_bit_reader_if #(
    parameter int unsigned BUF_W = 32,
    parameter int unsigned WIN_W = 16,
    parameter int unsigned LEN_W = 5
);
    localparam int unsigned FILL_W = $clog2(BUF_W + 1);

    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic [WIN_W-1:0]  peek_bits;
    logic [FILL_W-1:0] fill_level;
    logic              peek_valid;
    logic              consume_en;
    logic [LEN_W-1:0]  consume_len;
    logic              marker_valid;
    logic [7:0]        marker_code;
    logic              marker_ack;
    logic              err;

    modport master (
        output in_valid, in_data, consume_en, consume_len, marker_ack,
        input  in_ready, peek_bits, fill_level, peek_valid, marker_valid, marker_code, err
    );

    modport slave (
        input  in_valid, in_data, consume_en, consume_len, marker_ack,
        output in_ready, peek_bits, fill_level, peek_valid, marker_valid, marker_code, err
    );
endinterface

// File: rtl/jpeg_unstuff_bit_reader.sv
// JPEG entropy-stream front end: strips FF00 stuffing, traps markers and offers an
// MSB-first bit window from which the Huffman decoder consumes a variable bit count.
module jpeg_unstuff_bit_reader #(
    parameter int unsigned BUF_W = 32,
    parameter int unsigned WIN_W = 16,
    parameter int unsigned LEN_W = 5
) (
    input logic clk,
    input logic rst_n,
    jpeg_unstuff_bit_reader_if.slave bus
);
    localparam int unsigned FillW = $clog2(BUF_W + 1);

    typedef enum logic [1:0] {StNormal, StGotFf, StMarker} state_e;

    state_e             state_q, state_d;
    logic [BUF_W-1:0]   buf_q, buf_d, buf_mid, app_ext;
    logic [FillW-1:0]   fill_q, fill_d, fill_mid;
    logic [7:0]         code_q, code_d, app_byte;
    logic               err_q, err_d;
    logic               accept, append, consume_bad, consume_ok;
    logic [31:0]        len32, fill32;

    assign len32  = 32'(bus.consume_len);
    assign fill32 = 32'(fill_q);

    assign bus.in_ready     = (state_q != StMarker) && (fill32 <= BUF_W - 8);
    assign bus.peek_bits    = buf_q[BUF_W-1 -: WIN_W];
    assign bus.fill_level   = fill_q;
    assign bus.peek_valid   = fill32 >= WIN_W;
    assign bus.marker_valid = state_q == StMarker;
    assign bus.marker_code  = code_q;
    assign bus.err          = err_q;

    assign accept      = bus.in_valid && bus.in_ready;
    assign consume_bad = bus.consume_en && ((len32 > WIN_W) || (len32 > fill32));
    assign consume_ok  = bus.consume_en && !consume_bad;

    // Consumed bits leave from the top; zeros shift in so bits past fill stay clear.
    assign buf_mid  = consume_ok ? (buf_q << bus.consume_len) : buf_q;
    assign fill_mid = consume_ok ? (fill_q - FillW'(bus.consume_len)) : fill_q;

    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        err_d    = err_q | consume_bad;
        append   = 1'b0;
        app_byte = bus.in_data;

        unique case (state_q)
            StNormal: begin
                if (accept) begin
                    if (bus.in_data == 8'hFF) state_d = StGotFf;
                    else                      append  = 1'b1;
                end
            end
            StGotFf: begin
                if (accept) begin
                    if (bus.in_data == 8'h00) begin
                        append   = 1'b1;
                        app_byte = 8'hFF;
                        state_d  = StNormal;
                    end else if (bus.in_data != 8'hFF) begin
                        code_d  = bus.in_data;
                        state_d = StMarker;
                    end
                end
            end
            StMarker: begin
                state_d = StMarker;
            end
            default: state_d = StNormal;
        endcase

        // New byte lands directly beneath whatever survives this cycle's consume.
        app_ext = {app_byte, {(BUF_W - 8){1'b0}}};
        buf_d   = buf_mid;
        fill_d  = fill_mid;
        if (append) begin
            buf_d  = buf_mid | (app_ext >> fill_mid);
            fill_d = fill_mid + FillW'(8);
        end

        // Ack flushes everything, overriding any consume in the same cycle.
        if (state_q == StMarker && bus.marker_ack) begin
            buf_d   = '0;
            fill_d  = '0;
            state_d = StNormal;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StNormal;
            buf_q   <= '0;
            fill_q  <= '0;
            code_q  <= 8'h00;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            fill_q  <= fill_d;
            code_q  <= code_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_jpeg_unstuff_bit_reader.sv
// Directed bench for the JPEG unstuffing bit reader: stuffing, markers,
// backpressure, error stickiness and reset in the middle of an FF pair.
module tb_jpeg_unstuff_bit_reader;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    jpeg_unstuff_bit_reader_if #(.BUF_W(32), .WIN_W(16), .LEN_W(5)) bus ();

    jpeg_unstuff_bit_reader #(.BUF_W(32), .WIN_W(16), .LEN_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: inputs held across the edge, released #1 after it.
    task automatic cycle(input logic v, input logic [7:0] d, input logic ce,
                         input logic [4:0] cl, input logic ack);
        bus.in_valid    = v;
        bus.in_data     = d;
        bus.consume_en  = ce;
        bus.consume_len = cl;
        bus.marker_ack  = ack;
        @(posedge clk);
        #1;
        bus.in_valid    = 1'b0;
        bus.in_data     = 8'h00;
        bus.consume_en  = 1'b0;
        bus.consume_len = 5'd0;
        bus.marker_ack  = 1'b0;
    endtask

    task automatic push(input logic [7:0] d);
        cycle(1'b1, d, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic take(input logic [4:0] n);
        cycle(1'b0, 8'h00, 1'b1, n, 1'b0);
    endtask

    initial begin
        n_checks        = 0;
        n_errors        = 0;
        rst_n           = 1'b0;
        bus.in_valid    = 1'b0;
        bus.in_data     = 8'h00;
        bus.consume_en  = 1'b0;
        bus.consume_len = 5'd0;
        bus.marker_ack  = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        check("rst_fill", 32'(bus.fill_level), 32'd0);
        check("rst_peek", 32'(bus.peek_bits), 32'h0);
        check("rst_pv", 32'(bus.peek_valid), 32'd0);
        check("rst_mv", 32'(bus.marker_valid), 32'd0);
        check("rst_code", 32'(bus.marker_code), 32'h0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_rdy", 32'(bus.in_ready), 32'd1);

        // Plain bytes, then partial consume exposing zero fill below valid bits
        push(8'h12);
        push(8'h34);
        check("t1_fill", 32'(bus.fill_level), 32'd16);
        check("t1_peek", 32'(bus.peek_bits), 32'h1234);
        check("t1_pv", 32'(bus.peek_valid), 32'd1);
        take(5'd4);
        check("t1_fill4", 32'(bus.fill_level), 32'd12);
        check("t1_peek4", 32'(bus.peek_bits), 32'h2340);
        check("t1_pv4", 32'(bus.peek_valid), 32'd0);
        take(5'd12);
        check("t1_empty", 32'(bus.fill_level), 32'd0);

        // Stuffed FF
        push(8'hFF);
        check("t2_ff_hidden", 32'(bus.fill_level), 32'd0);
        push(8'h00);
        push(8'hA5);
        check("t2_fill", 32'(bus.fill_level), 32'd16);
        check("t2_peek", 32'(bus.peek_bits), 32'hFFA5);
        check("t2_mv", 32'(bus.marker_valid), 32'd0);
        take(5'd16);

        // Marker with fill byte
        push(8'h7E);
        push(8'hFF);
        push(8'hFF);
        push(8'hD3);
        check("t3_fill", 32'(bus.fill_level), 32'd8);
        check("t3_mv", 32'(bus.marker_valid), 32'd1);
        check("t3_code", 32'(bus.marker_code), 32'hD3);
        check("t3_rdy", 32'(bus.in_ready), 32'd0);
        check("t3_peek", 32'(bus.peek_bits), 32'h7E00);
        push(8'h55);
        check("t3_stall", 32'(bus.fill_level), 32'd8);
        take(5'd8);
        check("t3_drain", 32'(bus.fill_level), 32'd0);
        check("t3_mv_hold", 32'(bus.marker_valid), 32'd1);
        cycle(1'b0, 8'h00, 1'b0, 5'd0, 1'b1);
        check("t3_ack_mv", 32'(bus.marker_valid), 32'd0);
        check("t3_ack_rdy", 32'(bus.in_ready), 32'd1);

        // Ack together with consume: ack wins
        push(8'h11);
        push(8'hFF);
        push(8'hD9);
        check("t3b_code", 32'(bus.marker_code), 32'hD9);
        cycle(1'b0, 8'h00, 1'b1, 5'd4, 1'b1);
        check("t3b_fill", 32'(bus.fill_level), 32'd0);
        check("t3b_mv", 32'(bus.marker_valid), 32'd0);
        check("t3b_err", 32'(bus.err), 32'd0);

        // Ack outside MARKER is ignored
        push(8'h22);
        cycle(1'b0, 8'h00, 1'b0, 5'd0, 1'b1);
        check("t3c_fill", 32'(bus.fill_level), 32'd8);
        check("t3c_peek", 32'(bus.peek_bits), 32'h2200);
        take(5'd8);

        // Backpressure
        push(8'hAA);
        push(8'hBB);
        push(8'hCC);
        push(8'hDD);
        check("t4_full", 32'(bus.fill_level), 32'd32);
        check("t4_rdy0", 32'(bus.in_ready), 32'd0);
        check("t4_peek", 32'(bus.peek_bits), 32'hAABB);
        push(8'hEE);
        check("t4_refused", 32'(bus.fill_level), 32'd32);
        take(5'd8);
        check("t4_fill24", 32'(bus.fill_level), 32'd24);
        check("t4_rdy1", 32'(bus.in_ready), 32'd1);
        check("t4_peek24", 32'(bus.peek_bits), 32'hBBCC);
        cycle(1'b1, 8'hEE, 1'b1, 5'd3, 1'b0);
        check("t4_fill29", 32'(bus.fill_level), 32'd29);
        check("t4_peek29", 32'(bus.peek_bits), 32'hDE66);
        take(5'd16);
        take(5'd13);
        check("t4_empty", 32'(bus.fill_level), 32'd0);

        // Over-consume and oversize length; error is sticky
        push(8'h5A);
        take(5'd9);
        check("t5_fill", 32'(bus.fill_level), 32'd8);
        check("t5_peek", 32'(bus.peek_bits), 32'h5A00);
        check("t5_err", 32'(bus.err), 32'd1);
        cycle(1'b1, 8'h3C, 1'b1, 5'd20, 1'b0);
        check("t5_app_fill", 32'(bus.fill_level), 32'd16);
        check("t5_app_peek", 32'(bus.peek_bits), 32'h5A3C);
        take(5'd16);
        push(8'h01);
        check("t5_fill_after", 32'(bus.fill_level), 32'd8);
        check("t5_err_sticky", 32'(bus.err), 32'd1);

        // Reset while an FF is pending
        take(5'd8);
        push(8'hFF);
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        check("t6_rst_err", 32'(bus.err), 32'd0);
        check("t6_rst_fill", 32'(bus.fill_level), 32'd0);
        push(8'h00);
        check("t6_fill", 32'(bus.fill_level), 32'd8);
        check("t6_peek", 32'(bus.peek_bits), 32'h0000);
        check("t6_mv", 32'(bus.marker_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
